// File: rtl/icache_pkg.sv
// Shared types and elaboration helpers for the set-associative instruction-cache controller.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    REFILL,
    TAGWR,
    READ,
    FLUSH
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Byte offset width of a line: word-select bits plus the two byte bits.
  function automatic int off_bits(input int line_words);
    return clog2(line_words) + 2;
  endfunction

  function automatic int index_msb(input int line_words, input int index_bits);
    return off_bits(line_words) + index_bits - 1;
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] sel);
    return 16'(1) << sel;
  endfunction

endpackage

// File: rtl/icache_ctrl_sa_if.sv
// Fetch, tag/data SRAM and IM refill signals of the instruction-cache controller.
interface icache_ctrl_sa_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 64
);
  logic [ADDR_W-1:0]     address;
  logic                  Icache_en;
  logic                  ready;
  logic [WAYS-1:0]       hit_way;
  logic                  stall_in;
  logic                  flush;

  logic [WAYS-1:0]       tag_cs;
  logic                  tag_oe;
  logic [WAYS-1:0]       tag_web;
  logic [LINE_WORDS-1:0] data_cs;
  logic                  data_oe;
  logic [WAYS-1:0]       data_web;
  logic [WAYS-1:0]       rd_way;
  logic                  Istall;
  logic                  IM_enable;
  logic [ADDR_W-1:0]     IM_address;
  logic [CNT_W-1:0]      perf_access;
  logic [CNT_W-1:0]      perf_miss;

  modport master (
    input  address, Icache_en, ready, hit_way, stall_in, flush,
    output tag_cs, tag_oe, tag_web, data_cs, data_oe, data_web, rd_way,
           Istall, IM_enable, IM_address, perf_access, perf_miss
  );

  modport slave (
    output address, Icache_en, ready, hit_way, stall_in, flush,
    input  tag_cs, tag_oe, tag_web, data_cs, data_oe, data_web, rd_way,
           Istall, IM_enable, IM_address, perf_access, perf_miss
  );
endinterface

// File: rtl/icache_repl.sv
// Per-set valid bits, LRU state and victim choice for the instruction cache.
module icache_repl
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [WAYS-1:0]       hit_vec,
  input  logic                  fill,
  input  logic [WAYS-1:0]       fill_way,
  input  logic                  update,
  input  logic                  read_way0,
  input  logic                  flush,
  output logic                  hit,
  output logic [WAYS-1:0]       hit_valid,
  output logic [WAYS-1:0]       victim
);
  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0][WAYS-1:0] valid;

  // NOTE: valid bits live in flops rather than the SRAM macros so that reset and
  // flush can clear every set in one cycle; the tag/data arrays are never reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[index] <= valid[index] | fill_way;
    end
  end

  assign hit_valid = hit_vec & valid[index];
  assign hit       = |hit_valid;

  if (WAYS == 2) begin : g_two_way
    logic [SETS-1:0] lru;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        lru <= '0;
      end else if (update) begin
        // Evict next the way that was not just read.
        lru[index] <= read_way0;
      end
    end

    always_comb begin
      if (!valid[index][0])      victim = 2'b01;
      else if (!valid[index][1]) victim = 2'b10;
      else                       victim = lru[index] ? 2'b10 : 2'b01;
    end
  end else begin : g_one_way
    assign victim = 1'b1;
  end

endmodule

// File: rtl/icache_ctrl_sa.sv
// Instruction-cache controller: lookup, line refill from IM, tag write, read-out and flush.
module icache_ctrl_sa
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 6,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 64
) (
  input logic              clk,
  input logic              rst,
  icache_ctrl_sa_if.master bus
);
  localparam int OFF    = off_bits(LINE_WORDS);
  localparam int WORD_W = clog2(LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST = WORD_W'(LINE_WORDS - 1);

  state_t state, next_state;

  logic [WORD_W-1:0]     cnt;
  logic [WAYS-1:0]       victim_q;
  logic [WAYS-1:0]       hit_valid_q;
  logic                  hit_q;
  logic                  flush_pend;
  logic [CNT_W-1:0]      access_q;
  logic [CNT_W-1:0]      miss_q;

  logic [INDEX_BITS-1:0] index;
  logic [WORD_W-1:0]     word;
  logic                  beat;
  logic                  hit;
  logic [WAYS-1:0]       hit_valid;
  logic [WAYS-1:0]       victim;
  logic [WAYS-1:0]       rd_sel;

  assign index  = bus.address[index_msb(LINE_WORDS, INDEX_BITS):OFF];
  assign word   = bus.address[OFF-1:2];
  assign beat   = bus.ready && !bus.stall_in;
  assign rd_sel = hit_q ? hit_valid_q : victim_q;

  icache_repl #(
    .INDEX_BITS(INDEX_BITS),
    .WAYS      (WAYS)
  ) u_repl (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .hit_vec  (bus.hit_way),
    .fill     (state == TAGWR),
    .fill_way (victim_q),
    .update   (state == READ),
    .read_way0(rd_sel[0]),
    .flush    (state == FLUSH),
    .hit      (hit),
    .hit_valid(hit_valid),
    .victim   (victim)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      victim_q    <= '0;
      hit_valid_q <= '0;
      hit_q       <= 1'b0;
      flush_pend  <= 1'b0;
      access_q    <= '0;
      miss_q      <= '0;
    end else begin
      if (state == REFILL && beat) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      if (state == COMPARE) begin
        hit_q       <= hit;
        hit_valid_q <= hit_valid;
        if (!hit) victim_q <= victim;
        if (access_q != {CNT_W{1'b1}}) access_q <= access_q + 1'b1;
        if (!hit && miss_q != {CNT_W{1'b1}}) miss_q <= miss_q + 1'b1;
      end
      // A flush seen mid-access is remembered and serviced once back in IDLE.
      if (state == FLUSH)                    flush_pend <= 1'b0;
      else if (bus.flush && state != IDLE)   flush_pend <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.flush || flush_pend) next_state = FLUSH;
        else if (bus.Icache_en)      next_state = LOOKUP;
      end
      LOOKUP:  next_state = COMPARE;
      COMPARE: next_state = hit ? READ : REFILL;
      REFILL:  if (beat && cnt == LAST) next_state = TAGWR;
      TAGWR:   next_state = READ;
      READ:    next_state = IDLE;
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.tag_cs     = '0;
    bus.tag_oe     = 1'b0;
    bus.tag_web    = '1;
    bus.data_cs    = '0;
    bus.data_oe    = 1'b0;
    bus.data_web   = '1;
    bus.rd_way     = '0;
    bus.Istall     = 1'b1;
    bus.IM_enable  = 1'b0;
    bus.IM_address = bus.address;
    case (state)
      IDLE: bus.Istall = bus.Icache_en || bus.flush || flush_pend;
      LOOKUP: begin
        bus.tag_cs = '1;
        bus.tag_oe = 1'b1;
      end
      REFILL: begin
        bus.IM_enable  = 1'b1;
        bus.IM_address = {bus.address[ADDR_W-1:OFF], cnt, 2'b00};
        bus.data_cs    = LINE_WORDS'(onehot(4'(cnt)));
        bus.data_web   = bus.stall_in ? '1 : ~victim_q;
      end
      TAGWR: begin
        bus.tag_cs  = victim_q;
        bus.tag_web = ~victim_q;
      end
      READ: begin
        bus.data_oe = 1'b1;
        bus.data_cs = LINE_WORDS'(onehot(4'(word)));
        bus.rd_way  = rd_sel;
        bus.Istall  = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.perf_access = access_q;
  assign bus.perf_miss   = miss_q;

endmodule

// File: doc/icache_ctrl_sa.md
Name: icache_ctrl_sa

Overview:
- Parametrised instruction-cache controller and next generation of the direct-mapped L1I controller.
- Supports 1 or 2 ways, configurable line length, on-chip valid/LRU state and a flush operation.
- Drives the tag and data SRAM macros and the instruction-memory refill port, and stalls the fetch stage.
- Sits between the IF stage, the L1I tag/data arrays and the IM bus.

Parameters:
- ADDR_W, 32: byte-address width.
- LINE_WORDS, 4: 32-bit words per line; power of 2, 2..16.
- INDEX_BITS, 6: set-index width; SETS = 2**INDEX_BITS.
- WAYS, 2: associativity; 1 or 2 only.
- CNT_W, 64: width of the performance counters.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous, active-high.
- address, in, ADDR_W: fetch byte address; held stable by the core while Istall=1.
- Icache_en, in, 1: fetch request.
- ready, in, 1: IM word valid this cycle.
- hit_way, in, WAYS: per-way tag-compare result from the tag arrays; valid in COMPARE.
- stall_in, in, 1: external hold (WFI or D-side count); freezes refill progress.
- flush, in, 1: invalidate-all request (pulse).
- tag_cs, out, WAYS: tag SRAM chip-select per way.
- tag_oe, out, 1: tag SRAM output enable.
- tag_web, out, WAYS: tag SRAM write enable per way, active-low.
- data_cs, out, LINE_WORDS: one-hot word-bank select.
- data_oe, out, 1: data SRAM output enable.
- data_web, out, WAYS: data SRAM write enable per way, active-low.
- rd_way, out, WAYS: one-hot way that muxes read data to IF.
- Istall, out, 1: fetch stall.
- IM_enable, out, 1: IM read request.
- IM_address, out, ADDR_W: IM word address.
- perf_access, out, CNT_W: lookups performed.
- perf_miss, out, CNT_W: lookups that missed.

Behaviour:
- Address split: word = address[OFF-1:2] with OFF = log2(LINE_WORDS)+2; index = address[OFF+INDEX_BITS-1:OFF].
- Internal state: valid[SETS][WAYS] and, when WAYS=2, lru[SETS] (1 bit = way to evict next).
- Reset: state IDLE, all valid=0, lru=0, refill counter 0, both perf counters 0, flush_pend=0.
- Outputs in reset and IDLE:
  - tag_cs=0, tag_oe=0, tag_web=all 1, data_oe=0, data_web=all 1, data_cs=0, rd_way=0.
  - IM_enable=0, IM_address=address, Istall=Icache_en|flush|flush_pend.
- States:
  - IDLE: if flush|flush_pend -> FLUSH; else if Icache_en -> LOOKUP.
  - LOOKUP: tag_cs=all 1, tag_oe=1 -> COMPARE.
  - COMPARE: hit = |(hit_way & valid[index]). On hit -> READ; on miss -> REFILL with victim latched.
    - Victim: first invalid way, else lru[index]; WAYS=1 always way 0.
    - perf_access+1; perf_miss+1 on a miss. Both counters saturate at all ones.
  - REFILL:
    - IM_enable=1, IM_address={address[ADDR_W-1:OFF], cnt, 2'b00}.
    - data_cs=1<<cnt, data_web=victim bit low, data_oe=0.
    - cnt advances only on ready && !stall_in.
    - On ready && !stall_in && cnt==LINE_WORDS-1 -> TAGWR and cnt clears.
    - With stall_in=1, cnt holds, IM_enable stays 1 and no write strobe is issued (data_web all 1).
  - TAGWR: tag_cs=victim, tag_web=victim low, valid[index][victim]=1 -> READ.
  - READ:
    - tag_cs=0, data_oe=1, data_cs=1<<word, rd_way = hit ? hit_way&valid : victim, Istall=0.
    - When WAYS=2, lru[index] = the way not read.
    - -> IDLE.
  - FLUSH: all valid=0, lru=0, flush_pend=0, Istall=1 -> IDLE.
- Flush handling:
  - flush outside IDLE sets flush_pend; the current access completes first (the READ still delivers its data).
  - flush and Icache_en together in IDLE: flush wins and the request is serviced afterwards.
- Latency:
  - Hit: READ occurs 3 cycles after the Icache_en cycle in IDLE.
  - Miss: 3 + LINE_WORDS accepted beats + stall cycles + 1.
- Refill beats must not be reordered; the counter always wraps to 0 after a line completes.
- Reset asserted mid-REFILL: return to IDLE next edge, cnt=0, all valid cleared, so the partial line is never marked valid.

Decomposition:
- Package icache_pkg holds:
  - the state enum (IDLE, LOOKUP, COMPARE, REFILL, TAGWR, READ, FLUSH);
  - OFF/index derivation functions;
  - the onehot/clog2 helpers.
- Sub-module icache_repl: valid + LRU arrays and victim selection, with ports index, hit_vec, update, flush.

Test Plan:
- Cold miss, WAYS=2, LINE_WORDS=4, address 0x0000_0048, ready always 1:
  - IM_address sequence 0x40, 0x44, 0x48, 0x4C;
  - then TAGWR with tag_web=2'b10, READ with data_cs=4'b0100 and rd_way=01;
  - perf_access=1, perf_miss=1.
- Re-fetch 0x48 with hit_way=01: READ 3 cycles after the request, IM_enable never set, perf_miss still 1.
- Same index, different tag, two misses:
  - first miss fills way 1 (invalid way);
  - second miss evicts per LRU, way 0.
- stall_in=1 for 5 cycles at cnt=2 with ready=1:
  - cnt holds at 2 and IM_address is held;
  - data_web stays all 1 during the stall;
  - refill completes afterwards with correct words.
- flush pulsed during REFILL:
  - the line completes and is delivered, then FLUSH;
  - the next fetch of the same address misses (perf_miss increments).
- rst held for 1 cycle mid-REFILL: outputs return to IDLE values, counters read 0, the next fetch misses.
